// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, sync pulses and display enable.
// Define VGA_PIXEL_DIV_EN to derive the pixel tick from a divide-by-4 of clk.
module vga_timing_gen #(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_DISP);
    localparam logic [9:0] V_VIS        = 10'(V_DISP);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISP + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

`ifdef VGA_PIXEL_DIV_EN
    logic [1:0] div_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 2'd0;
        end else begin
            div_q <= div_q + 2'd1;
        end
    end

    assign pix_tick = (div_q == 2'd3);
`else
    assign pix_tick = rst_n;
`endif

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       h_wrap, v_wrap;
    logic       hsync_q, vsync_q, valid_q, line_start_q, frame_start_q;

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (pix_tick) begin
            if (h_q == H_MAX) begin
                h_d    = 10'd0;
                h_wrap = 1'b1;
                if (v_q == V_MAX) begin
                    v_d    = 10'd0;
                    v_wrap = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Decodes are taken from the next counter value so they line up with the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            valid_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= !((h_d >= H_SYNC_START) && (h_d < H_SYNC_END));
            vsync_q       <= !((v_d >= V_SYNC_START) && (v_d < V_SYNC_END));
            valid_q       <= (h_d < H_VIS) && (v_d < V_VIS);
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a shrunken
// raster instance so full frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_PIXEL_DIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    localparam int AHD = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVD = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int BHD = 16,  BHF = 4,  BHS = 6,  BHB = 6;
    localparam int BVD = 12,  BVF = 3,  BVS = 2,  BVB = 4;
    localparam int BHT = BHD + BHF + BHS + BHB;
    localparam int BVT = BVD + BVF + BVS + BVB;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic       a_pt, a_hs, a_vs, a_vl, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_pt, b_hs, b_vs, b_vl, b_ls, b_fs;
    logic [9:0] b_h, b_v;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_a), .pix_tick(a_pt), .h_cnt(a_h), .v_cnt(a_v),
        .hsync(a_hs), .vsync(a_vs), .valid(a_vl), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_DISP(BHD), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_DISP(BVD), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .pix_tick(b_pt), .h_cnt(b_h), .v_cnt(b_v),
        .hsync(b_hs), .vsync(b_vs), .valid(b_vl), .line_start(b_ls), .frame_start(b_fs)
    );

    logic [25:0] act_a, act_b;
    assign act_a = {a_h, a_v, a_hs, a_vs, a_vl, a_ls, a_fs, a_pt};
    assign act_b = {b_h, b_v, b_hs, b_vs, b_vl, b_ls, b_fs, b_pt};

    // Clock edges seen since each instance left reset.
    int ka = 0, kb = 0;
    always @(posedge clk) begin
        ka <= rst_a ? ka + 1 : 0;
        kb <= rst_b ? kb + 1 : 0;
    end

    int checks = 0;
    int errors = 0;

    // Reference: pixel position is simply ticks-since-reset folded into the raster.
    function automatic logic [25:0] model(int k, logic rst, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, int vb);
        int  ht, vt, t, h, v;
        logic e_hs, e_vs, e_vl, e_ls, e_fs, e_pt;
        bit  just_ticked;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t  = k / DIV;
        h  = t % ht;
        v  = (t / ht) % vt;
        just_ticked = (k >= DIV) && (k % DIV == 0);
        e_hs = !((h >= hd + hf) && (h < hd + hf + hs));
        e_vs = !((v >= vd + vf) && (v < vd + vf + vs));
        e_vl = (h < hd) && (v < vd);
        e_ls = just_ticked && (h == 0);
        e_fs = just_ticked && (h == 0) && (v == 0);
        e_pt = rst && (k % DIV == DIV - 1);
        return {10'(h), 10'(v), e_hs, e_vs, e_vl, e_ls, e_fs, e_pt};
    endfunction

    function automatic logic [25:0] exp_a();
        return model(ka, rst_a, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB);
    endfunction

    function automatic logic [25:0] exp_b();
        return model(kb, rst_b, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) begin
            tick();
            checks++;
            if (act_a !== 26'h0000e00 && act_a !== exp_a()) begin
                errors++;
                $display("FAIL reset_a actual=%h expected=%h", act_a, exp_a());
            end
            checks++;
            if (act_b !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_b actual=%h expected=%h", act_b,
                         {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_line();
        int   hs_low, ls_cnt, fall_h;
        logic prev_vl;
        hs_low  = 0;
        ls_cnt  = 0;
        fall_h  = -1;
        prev_vl = 1'b1;
        rst_a   = 1'b1;
        repeat (802 * DIV) begin
            tick();
            checks++;
            if (act_a !== exp_a()) begin
                errors++;
                $display("FAIL line_cyc k=%0d actual=%h expected=%h", ka, act_a, exp_a());
            end
            if (a_hs == 1'b0) hs_low++;
            if (a_ls) ls_cnt++;
            if (prev_vl && !a_vl && fall_h < 0) fall_h = int'(a_h);
            prev_vl = a_vl;
        end
        checks++;
        if (hs_low != 96 * DIV) begin
            errors++;
            $display("FAIL hsync_width actual=%0d expected=%0d clk", hs_low, 96 * DIV);
        end
        checks++;
        if (ls_cnt != 1) begin
            errors++;
            $display("FAIL line_start_count actual=%0d expected=1", ls_cnt);
        end
        checks++;
        if (fall_h != 640) begin
            errors++;
            $display("FAIL valid_fall_h actual=%0d expected=640", fall_h);
        end
        checks++;
        if (a_v !== 10'd1) begin
            errors++;
            $display("FAIL v_after_line actual=%0d expected=1", a_v);
        end
    endtask

    task automatic test_frame();
        int   vs_low, fs_cnt, fs_k0, fs_k1, ls_miss, fall_h, fall_v;
        logic prev_vs;
        vs_low  = 0;
        fs_cnt  = 0;
        fs_k0   = -1;
        fs_k1   = -1;
        ls_miss = 0;
        fall_h  = -1;
        fall_v  = -1;
        prev_vs = 1'b1;
        rst_b   = 1'b1;
        repeat ((2 * BHT * BVT + 2 * BHT) * DIV) begin
            tick();
            checks++;
            if (act_b !== exp_b()) begin
                errors++;
                $display("FAIL frame_cyc k=%0d actual=%h expected=%h", kb, act_b, exp_b());
            end
            if (b_vs == 1'b0 && fs_cnt == 0) vs_low++;
            if (prev_vs && !b_vs && fall_v < 0) begin
                fall_h = int'(b_h);
                fall_v = int'(b_v);
            end
            prev_vs = b_vs;
            if (b_fs) begin
                if (!b_ls) ls_miss++;
                if (fs_cnt == 0) fs_k0 = kb;
                else if (fs_cnt == 1) fs_k1 = kb;
                fs_cnt++;
            end
        end
        checks++;
        if (vs_low != BVS * BHT * DIV) begin
            errors++;
            $display("FAIL vsync_width actual=%0d expected=%0d clk", vs_low, BVS * BHT * DIV);
        end
        checks++;
        if (fall_h != 0 || fall_v != BVD + BVF) begin
            errors++;
            $display("FAIL vsync_start actual=(%0d,%0d) expected=(0,%0d)",
                     fall_h, fall_v, BVD + BVF);
        end
        checks++;
        if (fs_cnt != 2 || ls_miss != 0) begin
            errors++;
            $display("FAIL frame_start_count actual=%0d (ls_miss=%0d) expected=2", fs_cnt,
                     ls_miss);
        end
        checks++;
        if (fs_k0 != BHT * BVT * DIV) begin
            errors++;
            $display("FAIL frame_first actual=%0d expected=%0d", fs_k0, BHT * BVT * DIV);
        end
        checks++;
        if (fs_k1 - fs_k0 != BHT * BVT * DIV) begin
            errors++;
            $display("FAIL frame_spacing actual=%0d expected=%0d", fs_k1 - fs_k0,
                     BHT * BVT * DIV);
        end
    endtask

    task automatic test_midframe_reset();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        // Park inside both sync pulses: h=22 (hsync 20..25), v=15 (vsync 15..16).
        repeat ((15 * BHT + 22) * DIV) tick();
        checks++;
        if ({b_hs, b_vs} !== 2'b00 || b_h !== 10'd22 || b_v !== 10'd15) begin
            errors++;
            $display("FAIL midframe_pre actual=(%0d,%0d,hs=%b,vs=%b) expected=(22,15,hs=0,vs=0)",
                     b_h, b_v, b_hs, b_vs);
        end
        rst_b = 1'b0;
        tick();
        checks++;
        if (act_b !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midframe_reset actual=%h expected=%h", act_b,
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random_resets();
        int run_len, hold_len;
        for (int it = 0; it < 6; it++) begin
            run_len  = int'($urandom_range(1, 800 * DIV));
            hold_len = int'($urandom_range(1, 3));
            rst_b    = 1'b1;
            repeat (run_len) begin
                tick();
                checks++;
                if (act_b !== exp_b()) begin
                    errors++;
                    $display("FAIL rand_run it=%0d k=%0d actual=%h expected=%h", it, kb, act_b,
                             exp_b());
                end
            end
            rst_b = 1'b0;
            repeat (hold_len) begin
                tick();
                checks++;
                if (act_b !== exp_b()) begin
                    errors++;
                    $display("FAIL rand_reset it=%0d actual=%h expected=%h", it, act_b,
                             exp_b());
                end
            end
        end
    endtask

    task automatic test_pix_tick();
        int         e, first_inc, last_inc, bad_gap, pt_cnt;
        logic [9:0] prev_h;
        rst_a = 1'b0;
        tick();
        rst_a     = 1'b1;
        e         = 0;
        first_inc = -1;
        last_inc  = 0;
        bad_gap   = 0;
        pt_cnt    = 0;
        prev_h    = a_h;
        repeat (16 * DIV) begin
            tick();
            e++;
            if (a_pt) pt_cnt++;
            if (a_h != prev_h) begin
                if (first_inc < 0) first_inc = e;
                else if (e - last_inc != DIV) bad_gap++;
                last_inc = e;
            end
            prev_h = a_h;
        end
        checks++;
        if (first_inc != DIV) begin
            errors++;
            $display("FAIL first_increment actual=%0d expected=%0d", first_inc, DIV);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL increment_gap bad=%0d expected=0", bad_gap);
        end
        checks++;
        if (pt_cnt != 16) begin
            errors++;
            $display("FAIL pix_tick_duty actual=%0d expected=16", pt_cnt);
        end
        checks++;
        if (a_h !== 10'd16) begin
            errors++;
            $display("FAIL h_after_ticks actual=%0d expected=16", a_h);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_midframe_reset();
        test_random_resets();
        test_pix_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
